// File: rtl/trig_pkg.sv
// Constants and state encoding shared by the coax trigger transmitter and the
// trigger-board receiver.
package trig_pkg;

    localparam int unsigned TRIG_NCH       = 16;
    localparam int unsigned TRIG_NPHASE    = 4;
    localparam int unsigned TRIG_NSYNC     = 54;
    localparam int unsigned TRIG_SYNC_SKIP = 210;

    typedef logic [$clog2(TRIG_NPHASE)-1:0] trig_phase_t;

    typedef logic [1:0] trig_state_t;
    localparam trig_state_t NORMAL     = 2'd0;
    localparam trig_state_t SYNC_WAIT  = 2'd1;
    localparam trig_state_t SYNC_PULSE = 2'd2;
    localparam trig_state_t SYNC_DONE  = 2'd3;

    // Bits needed to hold any value in 0..maxval.
    function automatic int unsigned cnt_width(input int unsigned maxval);
        return (maxval < 2) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/trig_tx_chan.sv
// One coax trigger channel: edge detect, holdoff, registered pulse output and
// a flag for each enabled edge that had to be dropped.
module trig_tx_chan
    import trig_pkg::*;
#(
    parameter int unsigned HOLDOFF = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic trig_i,
    input  logic enable_i,
    input  logic suppress_i,
    input  logic hold_clr_i,
    input  logic sync_fire_i,
    output logic coax_o,
    output logic drop_o
);

    localparam int unsigned HW = cnt_width(HOLDOFF);

    logic          trig_q;
    logic [HW-1:0] hold_q, hold_d;
    logic          coax_q, coax_d;
    logic          edge_det, hold_busy, accept;

    always_comb begin
        edge_det  = trig_i & ~trig_q;
        hold_busy = (hold_q != '0);
        accept    = edge_det & enable_i & ~suppress_i & ~hold_busy;
        drop_o    = edge_det & enable_i & (suppress_i | hold_busy);
        coax_d    = accept | (sync_fire_i & enable_i);

        hold_d = hold_q;
        if (hold_clr_i) begin
            hold_d = '0;
        end else if (accept) begin
            hold_d = HW'(HOLDOFF - 1);
        end else if (hold_busy) begin
            hold_d = hold_q - HW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trig_q <= 1'b0;
            hold_q <= '0;
            coax_q <= 1'b0;
        end else begin
            trig_q <= trig_i;
            hold_q <= hold_d;
            coax_q <= coax_d;
        end
    end

    assign coax_o = coax_q;

endmodule

// File: rtl/trig_tx_sync.sv
// Coax trigger transmitter: per-channel pulses in normal running, and a
// fixed-phase sync pulse train during each calibration window.
module trig_tx_sync
    import trig_pkg::*;
#(
    parameter int unsigned NCH        = TRIG_NCH,
    parameter int unsigned NSYNC      = TRIG_NSYNC,
    parameter int unsigned SYNC_SKIP  = TRIG_SYNC_SKIP,
    parameter int unsigned SYNC_PHASE = 0,
    parameter int unsigned HOLDOFF    = 4
) (
    input  logic            clk_adc,
    input  logic            nrst,
    input  logic [NCH-1:0]  trig_in,
    input  logic [NCH-1:0]  enable_mask,
    input  logic            sync_window,
    output logic [NCH-1:0]  coax_out,
    output trig_phase_t     phase,
    output logic            sync_done,
    output logic            sync_aborted,
    output logic [31:0]     drop_count
);

    localparam int unsigned SKW = cnt_width(SYNC_SKIP);
    localparam int unsigned PCW = cnt_width(NSYNC);
    localparam int unsigned DSW = cnt_width(NCH);

    // Pulse decisions are made one cycle ahead because coax_out is registered.
    localparam logic [SKW-1:0] SKIP_LAST = SKW'(SYNC_SKIP - 1);
    localparam logic [PCW-1:0] NSYNC_V   = PCW'(NSYNC);
    localparam trig_phase_t    SYNC_PH   = trig_phase_t'(SYNC_PHASE);

    trig_state_t    state_q, state_d;
    trig_phase_t    phase_q;
    logic           win_q;
    logic [SKW-1:0] skip_q, skip_d;
    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic           aborted_q, aborted_d;
    logic [31:0]    drop_q, drop_d;

    logic           win_rise, in_sync, phase_hit;
    logic           suppress, hold_clr, sync_fire;
    logic [NCH-1:0] drop_vec;
    logic [DSW-1:0] drop_sum;
    logic [32:0]    drop_acc;

    always_comb begin
        win_rise  = sync_window & ~win_q;
        in_sync   = (state_q != NORMAL);
        phase_hit = ((phase_q + trig_phase_t'(1)) == SYNC_PH);

        state_d   = state_q;
        skip_d    = skip_q;
        pcnt_d    = pcnt_q;
        aborted_d = aborted_q;
        sync_fire = 1'b0;
        hold_clr  = 1'b0;

        if (win_rise) begin
            state_d   = SYNC_WAIT;
            skip_d    = '0;
            pcnt_d    = '0;
            aborted_d = 1'b0;
        end else if (in_sync && !sync_window) begin
            state_d  = NORMAL;
            skip_d   = '0;
            pcnt_d   = '0;
            hold_clr = 1'b1;
            if ((state_q == SYNC_WAIT) || (state_q == SYNC_PULSE && pcnt_q != NSYNC_V)) begin
                aborted_d = 1'b1;
            end
        end else begin
            case (state_q)
                SYNC_WAIT: begin
                    if (skip_q != SKIP_LAST) begin
                        skip_d = skip_q + SKW'(1);
                    end else if (phase_hit) begin
                        sync_fire = 1'b1;
                        pcnt_d    = PCW'(1);
                        state_d   = SYNC_PULSE;
                    end
                end
                SYNC_PULSE: begin
                    // Count reaches NSYNC while the last pulse is on the wire.
                    if (pcnt_q == NSYNC_V) begin
                        state_d = SYNC_DONE;
                    end else if (phase_hit) begin
                        sync_fire = 1'b1;
                        pcnt_d    = pcnt_q + PCW'(1);
                    end
                end
                default: ;
            endcase
        end

        suppress = win_rise | in_sync;
    end

    always_comb begin
        drop_sum = '0;
        for (int i = 0; i < NCH; i++) begin
            drop_sum = drop_sum + DSW'(drop_vec[i]);
        end
        drop_acc = {1'b0, drop_q} + 33'(drop_sum);
        drop_d   = drop_acc[32] ? '1 : drop_acc[31:0];
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        trig_tx_chan #(
            .HOLDOFF (HOLDOFF)
        ) u_chan (
            .clk_i       (clk_adc),
            .rst_ni      (nrst),
            .trig_i      (trig_in[g]),
            .enable_i    (enable_mask[g]),
            .suppress_i  (suppress),
            .hold_clr_i  (hold_clr),
            .sync_fire_i (sync_fire),
            .coax_o      (coax_out[g]),
            .drop_o      (drop_vec[g])
        );
    end

    // win_q resets high so a window already open at reset release is not a rise.
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            state_q   <= NORMAL;
            phase_q   <= '0;
            win_q     <= 1'b1;
            skip_q    <= '0;
            pcnt_q    <= '0;
            aborted_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_q + trig_phase_t'(1);
            win_q     <= sync_window;
            skip_q    <= skip_d;
            pcnt_q    <= pcnt_d;
            aborted_q <= aborted_d;
            drop_q    <= drop_d;
        end
    end

    assign phase        = phase_q;
    assign sync_done    = (state_q == SYNC_DONE);
    assign sync_aborted = aborted_q;
    assign drop_count   = drop_q;

endmodule
